// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: WIDTH-bit a +/- b, DIGIT bits per clock, LSB first.
// Define DIGIT_SERIAL_ADDSUB_OVF_EN to add the registered signed-overflow output ovf.
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             cout
`ifdef DIGIT_SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("digit_serial_addsub: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic [DIGIT:0]   dsum_d;
    logic [WIDTH-1:0] dig_ext_d;
    logic [WIDTH-1:0] r_d;
    logic             last_d;
`ifdef DIGIT_SERIAL_ADDSUB_OVF_EN
    logic             msb_cin_d;
`endif

    // One digit of the ripple: low digit of A + low digit of B' + carry flop.
    always_comb begin
        dsum_d    = {1'b0, a_q[DIGIT-1:0]}
                  + {1'b0, b_q[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry_q};
        dig_ext_d = WIDTH'(dsum_d[DIGIT-1:0]);
        r_d       = (r_q >> DIGIT) | (dig_ext_d << (WIDTH - DIGIT));
        last_d    = (cnt_q == CW'(N - 1));
`ifdef DIGIT_SERIAL_ADDSUB_OVF_EN
        // Carry into the top bit recovered from the top sum bit and its operands.
        msb_cin_d = dsum_d[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
`endif
    end

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            y       <= '0;
            cout    <= 1'b0;
`ifdef DIGIT_SERIAL_ADDSUB_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    r_q     <= r_d;
                    carry_q <= dsum_d[DIGIT];
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_d) begin
                        y       <= r_d;
                        cout    <= dsum_d[DIGIT];
`ifdef DIGIT_SERIAL_ADDSUB_OVF_EN
                        ovf     <= msb_cin_d ^ dsum_d[DIGIT];
`endif
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/digit_serial_addsub.md
# digit_serial_addsub

Parametrised multi-cycle adder/subtractor for the muldiv datapath. Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit first, holding the inter-digit carry in a flop. Trades latency for area against a full-width ripple chain of full-adder cells. Serves as the accumulate/subtract engine under the shift-add multiply and restoring-divide sequencers.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits
- DIGIT, 4, bits processed per cycle; WIDTH % DIGIT must be 0, otherwise elaboration error; N = WIDTH/DIGIT

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- sub  in  1  0 = a+b, 1 = a-b; sampled with start
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- busy  out  1  high while digits are being computed
- done  out  1  one-cycle pulse when the result is valid
- y  out  WIDTH  result
- cout  out  1  final carry out; for subtract, 1 = no borrow
- ovf  out  1  signed overflow; present only with the configuration macro

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, start=1:
  - latch A into the shift register.
  - latch B, inverted if sub=1.
  - carry <= sub; digit counter <= 0; go to RUN.
- RUN, each cycle:
  - low DIGIT bits of A + low DIGIT bits of B' + carry.
  - sum digit shifts into the internal result register from the top; carry updates; A and B' shift right by DIGIT; counter increments.
- RUN, after digit N-1:
  - y <= completed result; cout <= final carry; go to DONE.
- DONE lasts exactly one cycle, then IDLE unless start is high.
- y, cout and ovf change only at completion and hold until the next completion.
  - While busy they show the previous result.
- start while in RUN is ignored; no queueing.
- sub, a and b are don't-care except in the start-sampling cycle.
- Arithmetic is modulo 2^WIDTH.
- DIGIT == WIDTH gives N=1: a single-cycle RUN.
- DIGIT == 1 gives fully bit-serial operation.
- Reset, including mid-operation: state=IDLE, busy=0, done=0, y=0, cout=0, ovf=0, carry=0, counter=0. An operation in flight is abandoned with no done pulse.

## Timing
- start accepted at rising edge t0.
- busy=1 from after t0 through edge t0+N.
- Digits are computed at edges t0+1 .. t0+N.
- done=1 and y/cout/ovf valid from after edge t0+N; done falls after edge t0+N+1.
- Start-to-done latency: N cycles.
- Back-to-back: start held high during the DONE cycle is accepted at edge t0+N+1.
  - busy rises again, done falls.
  - Throughput is one operation per N+1 cycles.
- busy and done are never both high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- DIGIT_SERIAL_ADDSUB_OVF_EN defined:
  - the ovf port exists.
  - ovf = carry into bit WIDTH-1 XOR final carry, captured at completion alongside y.
  - ovf resets to 0.
- Not defined:
  - the ovf port and its logic are absent.
  - all other behaviour is identical.

## Test plan
- WIDTH=16, DIGIT=4: a=0x1234, b=0x0FFF, sub=0 -> done exactly 4 cycles after the start edge, y=0x2233, cout=0, ovf=0.
- sub=1:
  - a=0x0000, b=0x0001 -> y=0xFFFF, cout=0, ovf=0.
  - a=0x0005, b=0x0003 -> y=0x0002, cout=1.
- Boundary values, add:
  - a=0xFFFF, b=0x0001 -> y=0x0000, cout=1, ovf=0.
  - a=0x7FFF, b=0x0001 -> y=0x8000, cout=0, ovf=1 (macro on; port absent with macro off).
- Control:
  - start pulsed again 2 cycles into RUN with different operands -> ignored; first result delivered on time.
  - start held high through DONE -> second operation accepted; done pulses once per operation.
- Reset:
  - rst_n low 2 cycles into an operation -> busy, done, y and cout are 0 immediately (asynchronous).
  - no done pulse follows; the next start completes normally.
- Parameter sweep (DIGIT=1, 4, 16 at WIDTH=16; DIGIT=8 at WIDTH=32):
  - 1000 random a/b/sub each, compared against a golden model.
  - latency equals WIDTH/DIGIT in every case.
